// File: rtl/user_seq_capture.sv
// Captures N_ENTRIES player values from SW on enter-key presses and scores them against seq_fpga.
// Press-to-output latency 3 cycles; no backpressure; presses outside CAPTURE are dropped.
module user_seq_capture #(
  parameter int N_ENTRIES      = 4,
  parameter int W              = 4,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           enter_n,
  input  logic [W-1:0]                   SW,
  input  logic [N_ENTRIES*W-1:0]         seq_fpga,
  output logic [N_ENTRIES*W-1:0]         seq_user,
  output logic [$clog2(N_ENTRIES+1)-1:0] count,
  output logic                           busy,
  output logic                           end_User,
  output logic                           match,
  output logic                           end_time
);

  localparam int CW = $clog2(N_ENTRIES+1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES-1);
  localparam logic [CW-1:0] C_LAST = CW'(N_ENTRIES-1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, TIMEOUT} state_t;

  state_t                 state;
  logic                   s1, s2, s3;
  logic                   press_q;
  logic [TW-1:0]          timer;
  logic [N_ENTRIES*W-1:0] next_seq;
  logic                   last_press;

  assign next_seq   = {seq_user[(N_ENTRIES-1)*W-1:0], SW};
  assign last_press = press_q && (count == C_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state    <= IDLE;
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      press_q  <= 1'b0;
      timer    <= '0;
      seq_user <= '0;
      count    <= '0;
      busy     <= 1'b0;
      end_User <= 1'b0;
      match    <= 1'b0;
      end_time <= 1'b0;
    end else begin
      s1      <= enter_n;
      s2      <= s1;
      s3      <= s2;
      // Registered falling-edge pulse: one cycle per key press, however long it is held.
      press_q <= s3 & ~s2;

      if (start) begin
        state    <= CAPTURE;
        busy     <= 1'b1;
        timer    <= '0;
        seq_user <= '0;
        count    <= '0;
        end_User <= 1'b0;
        match    <= 1'b0;
        end_time <= 1'b0;
      end else if (state == CAPTURE) begin
        timer <= timer + 1'b1;
        if (press_q) begin
          seq_user <= next_seq;
          count    <= count + 1'b1;
        end
        // A completing press on the final timer cycle takes priority over the timeout.
        if (last_press) begin
          state    <= DONE;
          busy     <= 1'b0;
          end_User <= 1'b1;
          match    <= (next_seq == seq_fpga);
        end else if (timer == T_LAST) begin
          state    <= TIMEOUT;
          busy     <= 1'b0;
          end_time <= 1'b1;
        end
      end
    end
  end

endmodule
